// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W    = 2;
    localparam int unsigned FETCH_INSTR_W   = 12;
    localparam int unsigned FETCH_ROM_DEPTH = 4;
    localparam int unsigned FETCH_RESET_PC  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        ISSUE   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: wrap-around increment, branch/clear load, out-of-range fault.
module fetch_pc #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned ROM_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              clear_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_c,
    output logic              fault_o
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [EXT_W-1:0]  pc_inc;
    logic              target_oob;

    // One extra bit so the wrap compare works when ROM_DEPTH == 2**ADDR_W.
    assign pc_inc     = {1'b0, pc_q} + EXT_W'(1);
    assign target_oob = {1'b0, target_i} >= EXT_W'(ROM_DEPTH);

    always_comb begin
        pc_d    = pc_q;
        fault_d = 1'b0;
        if (branch_i) begin
            pc_d    = target_oob ? '0 : target_i;
            fault_d = target_oob;
        end else if (clear_i) begin
            pc_d = ADDR_W'(RESET_PC);
        end else if (inc_i) begin
            pc_d = (pc_inc == EXT_W'(ROM_DEPTH)) ? '0 : pc_inc[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_PC);
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_c = pc_d;
    assign fault_o   = fault_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: drives the ROM read, captures the word and offers it to decode.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned INSTR_W   = FETCH_INSTR_W,
    parameter int unsigned ROM_DEPTH = FETCH_ROM_DEPTH,
    parameter int unsigned RESET_PC  = FETCH_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               fault
);

    fetch_state_t       state_q, state_d;
    logic               pc_inc, pc_clear, pc_branch, capture;
    logic [ADDR_W-1:0]  pc, pc_next;

    logic               rom_en_q, instr_valid_q, busy_q;
    logic [ADDR_W-1:0]  rom_addr_q, instr_pc_q;
    logic [INSTR_W-1:0] instr_q;

    fetch_pc #(
        .ADDR_W    (ADDR_W),
        .ROM_DEPTH (ROM_DEPTH),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (pc_inc),
        .clear_i   (pc_clear),
        .branch_i  (pc_branch),
        .target_i  (branch_target),
        .pc_o      (pc),
        .pc_next_c (pc_next),
        .fault_o   (fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a redirect from any busy state overrides everything else.
    always_comb begin
        state_d   = state_q;
        pc_inc    = 1'b0;
        pc_clear  = 1'b0;
        pc_branch = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                capture = 1'b1;
                pc_inc  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (halt) begin
                        state_d  = IDLE;
                        pc_clear = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_valid && state_q != IDLE) begin
            pc_branch = 1'b1;
            pc_inc    = 1'b0;
            pc_clear  = 1'b0;
            capture   = 1'b0;
            state_d   = FETCH;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_en_q      <= 1'b0;
            rom_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rom_en_q      <= (state_d == FETCH);
            instr_valid_q <= (state_d == ISSUE);
            busy_q        <= (state_d != IDLE);
            if (state_d == FETCH) begin
                rom_addr_q <= pc_next;
            end
            if (capture) begin
                instr_q    <= rom_data;
                instr_pc_q <= pc;
            end
        end
    end

    assign rom_en      = rom_en_q;
    assign rom_addr    = rom_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

endmodule
